ahfp_div: RTL and testbench

AHFP_DIV -- requirements
Module: ahfp_div

---
 rtl/ahfp_div.sv | 167 ++++++++++++++++
 tb/tb_ahfp_div.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/ahfp_div.sv
// rtl/ahfp_div.sv - multi-cycle IEEE-754 single-precision divider (restoring, 1 bit/cycle)
//
// Purpose: computes result = dataa / datab with a fixed latency of 28 enabled
//   clock edges from the edge that accepts start. Denormal inputs are flushed
//   to signed zero; NaN inputs are treated as infinity.
// Optional feature: define AHFP_DIV_ROUND_EN for round half-up; otherwise the
//   quotient is truncated.
// Ports:
//   clk     in   1  rising-edge clock
//   reset_n in   1  asynchronous active-low reset
//   clk_en  in   1  when low every register holds
//   start   in   1  request; operands sampled on the accepting edge (IDLE only)
//   dataa   in  32  dividend
//   datab   in  32  divisor
//   result  out 32  quotient, held until the next completed operation
//   done    out  1  one enabled-cycle pulse when result is updated
//   busy    out  1  high from the accepting edge until done rises

module ahfp_div #(
  parameter int bias = 127
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clk_en,
  input  logic        start,
  input  logic [31:0] dataa,
  input  logic [31:0] datab,
  output logic [31:0] result,
  output logic        done,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, CALC, NORM, DONE} state_t;

  state_t state, state_next;

  logic [4:0]  cnt;
  logic [25:0] q;
  logic [24:0] rem;
  logic [23:0] div_m;
  logic [8:0]  a_se;      // captured {sign, exponent} of dataa
  logic [8:0]  b_se;      // captured {sign, exponent} of datab
  logic [31:0] pend;      // final word computed in NORM, published in DONE

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else if (clk_en) begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = CALC;
      CALC:    if (cnt == 5'd25) state_next = NORM;
      NORM:    state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // One restoring-division step: the remainder never exceeds 2*divisor, so
  // after a successful subtract (or a failed compare) bit 24 is always clear
  // and the left shift fits in 25 bits.
  logic        ge;
  logic [24:0] diff;

  assign ge   = (rem >= {1'b0, div_m});
  assign diff = rem - {1'b0, div_m};

  // Normalisation, rounding, range checks and special cases
  logic              sign;
  logic [7:0]        ea, eb;
  logic              a_zero, b_zero, a_inf, b_inf;
  logic [22:0]       frac_t, frac_f;
  logic signed [9:0] exp_t, exp_f;
  logic [31:0]       norm_word;
`ifdef AHFP_DIV_ROUND_EN
  logic              rbit;
  logic              carry;
`endif

  always_comb begin
    sign   = a_se[8] ^ b_se[8];
    ea     = a_se[7:0];
    eb     = b_se[7:0];
    a_zero = (ea == 8'd0);
    b_zero = (eb == 8'd0);
    a_inf  = (ea == 8'hFF);
    b_inf  = (eb == 8'hFF);

    frac_t = q[25] ? q[24:2] : q[23:1];
    exp_t  = $signed({2'b00, ea}) - $signed({2'b00, eb}) + $signed(10'(bias))
             - (q[25] ? 10'sd0 : 10'sd1);
`ifdef AHFP_DIV_ROUND_EN
    rbit            = q[25] ? q[1] : q[0];
    {carry, frac_f} = {1'b0, frac_t} + {23'd0, rbit};
    exp_f           = exp_t + $signed({9'd0, carry});
`else
    frac_f = frac_t;
    exp_f  = exp_t;
`endif

    if ((a_zero && b_zero) || (a_inf && b_inf)) begin
      norm_word = {sign, 31'h7FC00000};
    end else if (b_zero || a_inf) begin
      norm_word = {sign, 8'hFF, 23'd0};
    end else if (a_zero || b_inf) begin
      norm_word = {sign, 31'd0};
    end else if (exp_f <= 10'sd0) begin
      norm_word = 32'h00000000;
    end else if (exp_f >= 10'sd255) begin
      norm_word = {sign, 8'hFF, 23'd0};
    end else begin
      norm_word = {sign, exp_f[7:0], frac_f};
    end
  end

  // Datapath and outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt    <= 5'd0;
      q      <= 26'd0;
      rem    <= 25'd0;
      div_m  <= 24'd0;
      a_se   <= 9'd0;
      b_se   <= 9'd0;
      pend   <= 32'd0;
      result <= 32'd0;
      done   <= 1'b0;
      busy   <= 1'b0;
    end else if (clk_en) begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_se  <= dataa[31:23];
            b_se  <= datab[31:23];
            rem   <= {2'b01, dataa[22:0]};
            div_m <= {1'b1, datab[22:0]};
            q     <= 26'd0;
            cnt   <= 5'd0;
            busy  <= 1'b1;
          end
        end
        CALC: begin
          q   <= {q[24:0], ge};
          rem <= ge ? {diff[23:0], 1'b0} : {rem[23:0], 1'b0};
          cnt <= cnt + 5'd1;
        end
        NORM: begin
          pend <= norm_word;
        end
        DONE: begin
          result <= pend;
          done   <= 1'b1;
          busy   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ahfp_div.sv
// tb/tb_ahfp_div.sv - directed table-driven bench for ahfp_div
module tb_ahfp_div;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        clk_en = 1'b1;
  logic        start = 1'b0;
  logic [31:0] dataa = 32'd0;
  logic [31:0] datab = 32'd0;
  logic [31:0] result;
  logic        done;
  logic        busy;

  int n_vec = 0;
  int n_bad = 0;

  ahfp_div #(.bias(127)) dut (
    .clk(clk), .reset_n(reset_n), .clk_en(clk_en), .start(start),
    .dataa(dataa), .datab(datab), .result(result), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t tbl[16];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Called at a negedge with the DUT idle. Returns the number of clock edges
  // from the accepting edge to the edge that raised done (-1 on timeout).
  task automatic run_div(input logic [31:0] a, input logic [31:0] b,
                         input int second_at, input int stall_at, input int stall_len,
                         output int lat, output logic [31:0] res, output bit busy_ok);
    lat = -1;
    res = 32'hDEADBEEF;
    busy_ok = 1'b1;
    start = 1'b1;
    dataa = a;
    datab = b;
    clk_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (!busy) busy_ok = 1'b0;
    for (int k = 1; k <= 120; k++) begin
      start = (k == second_at);
      if (k == second_at) begin
        dataa = 32'h3F800000;
        datab = 32'h40400000;
      end
      clk_en = !(stall_len > 0 && k >= stall_at && k < stall_at + stall_len);
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        lat = k;
        res = result;
        if (busy) busy_ok = 1'b0;
        break;
      end
      if (!busy) busy_ok = 1'b0;
    end
    start = 1'b0;
    clk_en = 1'b1;
  endtask

  int          lat;
  logic [31:0] res;
  bit          bok;

  initial begin
    tbl[0]  = '{32'h40C00000, 32'h40000000, 32'h40400000, "6/2"};
`ifdef AHFP_DIV_ROUND_EN
    tbl[1]  = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAB, "1/3"};
`else
    tbl[1]  = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAA, "1/3"};
`endif
    tbl[2]  = '{32'hBF800000, 32'h00000000, 32'hFF800000, "-1/0"};
    tbl[3]  = '{32'h00000000, 32'h00000000, 32'h7FC00000, "0/0"};
    tbl[4]  = '{32'h00000000, 32'h40000000, 32'h00000000, "0/2"};
    tbl[5]  = '{32'h7F000000, 32'h00800000, 32'h7F800000, "overflow"};
    tbl[6]  = '{32'h00800000, 32'h40000000, 32'h00000000, "underflow"};
    tbl[7]  = '{32'h00800000, 32'h3F800000, 32'h00800000, "min_normal"};
    tbl[8]  = '{32'h7F7FFFFF, 32'h3F800000, 32'h7F7FFFFF, "max_normal"};
    tbl[9]  = '{32'hC0C00000, 32'h40000000, 32'hC0400000, "-6/2"};
    tbl[10] = '{32'h40000000, 32'h40800000, 32'h3F000000, "2/4"};
    tbl[11] = '{32'h7F800000, 32'h3F800000, 32'h7F800000, "inf/1"};
    tbl[12] = '{32'h3F800000, 32'h7F800000, 32'h00000000, "1/inf"};
    tbl[13] = '{32'h7F800000, 32'h7F800000, 32'h7FC00000, "inf/inf"};
    tbl[14] = '{32'h7FC00001, 32'h3F800000, 32'h7F800000, "nan_as_inf"};
    tbl[15] = '{32'h00000001, 32'h3F800000, 32'h00000000, "denorm_flush"};

    // reset state
    @(negedge clk);
    @(negedge clk);
    check32("reset_result", result, 32'h0);
    check32("reset_done", {31'd0, done}, 32'h0);
    check32("reset_busy", {31'd0, busy}, 32'h0);
    reset_n = 1'b1;
    @(negedge clk);

    foreach (tbl[i]) begin
      run_div(tbl[i].a, tbl[i].b, 0, 0, 0, lat, res, bok);
      check32(tbl[i].name, res, tbl[i].exp);
      check_int({tbl[i].name, "_latency"}, lat, 28);
      check_int({tbl[i].name, "_busy"}, int'(bok), 1);
      if (i == 0) begin
        @(posedge clk);
        @(negedge clk);
        check32("done_one_cycle", {31'd0, done}, 32'h0);
      end
    end

    // start while busy is ignored
    run_div(32'h40C00000, 32'h40000000, 5, 0, 0, lat, res, bok);
    check32("ignore_start_result", res, 32'h40400000);
    check_int("ignore_start_latency", lat, 28);
    check_int("ignore_start_busy", int'(bok), 1);

    // clk_en low for 7 cycles mid-CALC
    run_div(32'h40C00000, 32'h40000000, 0, 10, 7, lat, res, bok);
    check32("stall_result", res, 32'h40400000);
    check_int("stall_latency", lat, 35);

    // reset in flight: no done, result cleared, immediate restart accepted
    start = 1'b1;
    dataa = 32'h40C00000;
    datab = 32'h40000000;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) begin
      @(posedge clk);
      @(negedge clk);
    end
    reset_n = 1'b0;
    #1;
    check32("abort_result", result, 32'h0);
    check32("abort_done", {31'd0, done}, 32'h0);
    check32("abort_busy", {31'd0, busy}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    run_div(32'h40400000, 32'h40000000, 0, 0, 0, lat, res, bok);
    check32("after_reset_result", res, 32'h3FC00000);
    check_int("after_reset_latency", lat, 28);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
